// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART types and constants
package uart_pkg;

    // Receiver FSM states
    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PAR,
        STOP
    } rx_state_t;

    // Parity mode encoding
    localparam int PAR_NONE = 0;
    localparam int PAR_EVEN = 1;
    localparam int PAR_ODD  = 2;

    // Oversampling ticks per bit
    localparam int OVS = 16;

endpackage

// File: rtl/b_gen.sv
// rtl/b_gen.sv - mod-M baud tick generator
module b_gen #(
    parameter int M = 27,
    parameter int N = 5
) (
    input  logic         clk,
    input  logic         reset,
    output logic         max_tick,
    output logic [N-1:0] q
);

    logic [N-1:0] r_cnt;

    // Free-running counter that wraps at M-1
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_cnt <= '0;
        else if (r_cnt == N'(M - 1))
            r_cnt <= '0;
        else
            r_cnt <= r_cnt + N'(1);
    end

    assign q        = r_cnt;
    assign max_tick = (r_cnt == N'(M - 1));

endmodule

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - two-flop synchronizer with configurable reset value
module sync_2ff #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    // Two-stage capture of the asynchronous input
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_meta <= RST_VAL;
            r_sync <= RST_VAL;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 16x oversampling UART receiver
module uart_rx
    import uart_pkg::*;
#(
    parameter int DBIT    = 8,
    parameter int SB_TICK = 16,
    parameter int PARITY  = 0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            rx,
    input  logic            s_tick,
    output logic [DBIT-1:0] dout,
    output logic            rx_done_tick,
    output logic            frame_err,
    output logic            parity_err
);

    localparam int NW = $clog2(DBIT);

    // Expected parity-bit flip for odd mode
    localparam logic ODD_FLIP = (PARITY == PAR_ODD);

    logic w_rx_s;

    rx_state_t       r_state_reg, w_state_next;
    logic [4:0]      r_s_reg,     w_s_next;
    logic [NW-1:0]   r_n_reg,     w_n_next;
    logic [DBIT-1:0] r_b_reg,     w_b_next;
    logic            r_p_reg,     w_p_next;
    logic            r_perr_l_reg, w_perr_l_next;
    logic [DBIT-1:0] r_dout_reg,  w_dout_next;
    logic            r_done_reg,  w_done_next;
    logic            r_ferr_reg,  w_ferr_next;
    logic            r_perr_reg,  w_perr_next;

    sync_2ff #(.RST_VAL(1'b1)) u_rx_sync (
        .i_clk (clk),
        .i_rst (reset),
        .i_d   (rx),
        .o_q   (w_rx_s)
    );

    // State and output registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state_reg  <= IDLE;
            r_s_reg      <= '0;
            r_n_reg      <= '0;
            r_b_reg      <= '0;
            r_p_reg      <= 1'b0;
            r_perr_l_reg <= 1'b0;
            r_dout_reg   <= '0;
            r_done_reg   <= 1'b0;
            r_ferr_reg   <= 1'b0;
            r_perr_reg   <= 1'b0;
        end else begin
            r_state_reg  <= w_state_next;
            r_s_reg      <= w_s_next;
            r_n_reg      <= w_n_next;
            r_b_reg      <= w_b_next;
            r_p_reg      <= w_p_next;
            r_perr_l_reg <= w_perr_l_next;
            r_dout_reg   <= w_dout_next;
            r_done_reg   <= w_done_next;
            r_ferr_reg   <= w_ferr_next;
            r_perr_reg   <= w_perr_next;
        end
    end

    // Next-state logic: everything except the start-edge detect waits for s_tick
    always_comb begin
        w_state_next  = r_state_reg;
        w_s_next      = r_s_reg;
        w_n_next      = r_n_reg;
        w_b_next      = r_b_reg;
        w_p_next      = r_p_reg;
        w_perr_l_next = r_perr_l_reg;
        w_dout_next   = r_dout_reg;
        w_done_next   = 1'b0;
        w_ferr_next   = r_ferr_reg;
        w_perr_next   = r_perr_reg;

        case (r_state_reg)
            IDLE: begin
                if (!w_rx_s) begin
                    w_state_next = START;
                    w_s_next     = '0;
                end
            end
            START: begin
                if (s_tick) begin
                    if (r_s_reg == 5'(OVS / 2 - 1)) begin
                        if (!w_rx_s) begin
                            w_state_next = DATA;
                            w_s_next     = '0;
                            w_n_next     = '0;
                            w_p_next     = 1'b0;
                        end else begin
                            // Too short to be a start bit: treat as a glitch
                            w_state_next = IDLE;
                        end
                    end else begin
                        w_s_next = r_s_reg + 5'd1;
                    end
                end
            end
            DATA: begin
                if (s_tick) begin
                    if (r_s_reg == 5'(OVS - 1)) begin
                        w_b_next = {w_rx_s, r_b_reg[DBIT-1:1]};
                        w_p_next = r_p_reg ^ w_rx_s;
                        w_s_next = '0;
                        if (r_n_reg == NW'(DBIT - 1))
                            w_state_next = (PARITY != PAR_NONE) ? PAR : STOP;
                        else
                            w_n_next = r_n_reg + NW'(1);
                    end else begin
                        w_s_next = r_s_reg + 5'd1;
                    end
                end
            end
            PAR: begin
                if (s_tick) begin
                    if (r_s_reg == 5'(OVS - 1)) begin
                        w_perr_l_next = r_p_reg ^ w_rx_s ^ ODD_FLIP;
                        w_s_next      = '0;
                        w_state_next  = STOP;
                    end else begin
                        w_s_next = r_s_reg + 5'd1;
                    end
                end
            end
            STOP: begin
                if (s_tick) begin
                    if (r_s_reg == 5'(SB_TICK - 1)) begin
                        w_dout_next  = r_b_reg;
                        w_ferr_next  = ~w_rx_s;
                        w_perr_next  = (PARITY != PAR_NONE) ? r_perr_l_reg : 1'b0;
                        w_done_next  = 1'b1;
                        w_state_next = IDLE;
                    end else begin
                        w_s_next = r_s_reg + 5'd1;
                    end
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    assign dout         = r_dout_reg;
    assign rx_done_tick = r_done_reg;
    assign frame_err    = r_ferr_reg;
    assign parity_err   = r_perr_reg;

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - randomized self-checking bench for uart_rx
`timescale 1ns/1ps
module tb_uart_rx;
    import uart_pkg::*;

    localparam int BIT_NS  = 8640;
    localparam int TICK_NS = 540;

    logic       clk   = 1'b0;
    logic       reset = 1'b1;
    logic       rx0   = 1'b1;
    logic       rx1   = 1'b1;
    logic       rx2   = 1'b1;
    logic       s_tick;
    logic [4:0] bq;

    logic [7:0] dout0, dout1, dout2;
    logic       done0, done1, done2;
    logic       ferr0, ferr1, ferr2;
    logic       perr0, perr1, perr2;

    int n_checks = 0;
    int n_pass   = 0;

    logic [9:0] mon_q [3][$];
    longint     mon_t [3][$];

    always #10 clk = ~clk;

    b_gen #(.M(27), .N(5)) u_bgen (
        .clk(clk), .reset(reset), .max_tick(s_tick), .q(bq)
    );

    uart_rx #(.DBIT(8), .SB_TICK(16), .PARITY(PAR_NONE)) u_dut0 (
        .clk(clk), .reset(reset), .rx(rx0), .s_tick(s_tick), .dout(dout0),
        .rx_done_tick(done0), .frame_err(ferr0), .parity_err(perr0)
    );
    uart_rx #(.DBIT(8), .SB_TICK(16), .PARITY(PAR_EVEN)) u_dut1 (
        .clk(clk), .reset(reset), .rx(rx1), .s_tick(s_tick), .dout(dout1),
        .rx_done_tick(done1), .frame_err(ferr1), .parity_err(perr1)
    );
    uart_rx #(.DBIT(8), .SB_TICK(16), .PARITY(PAR_ODD)) u_dut2 (
        .clk(clk), .reset(reset), .rx(rx2), .s_tick(s_tick), .dout(dout2),
        .rx_done_tick(done2), .frame_err(ferr2), .parity_err(perr2)
    );

    // Capture every done pulse away from the active edge
    always @(negedge clk) begin
        if (done0) begin mon_q[0].push_back({perr0, ferr0, dout0}); mon_t[0].push_back($time); end
        if (done1) begin mon_q[1].push_back({perr1, ferr1, dout1}); mon_t[1].push_back($time); end
        if (done2) begin mon_q[2].push_back({perr2, ferr2, dout2}); mon_t[2].push_back($time); end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp)
            n_pass++;
        else
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    // Reference: {parity_err, frame_err, data} for a frame as sent on the wire
    function automatic logic [9:0] model(input logic [7:0] data, input int pmode,
                                         input logic pbit, input logic stop_lvl);
        int   ones;
        logic want;
        logic pe;
        ones = $countones(data);
        want = (pmode == PAR_EVEN) ? (ones % 2 == 1) : (ones % 2 == 0);
        pe   = (pmode != PAR_NONE) && (pbit != want);
        return {pe, ~stop_lvl, data};
    endfunction

    task automatic drive(input int line, input logic v);
        case (line)
            0:       rx0 = v;
            1:       rx1 = v;
            default: rx2 = v;
        endcase
    endtask

    // A low stop is held for 12 ticks only, so the re-armed start detect sees a glitch
    task automatic send_frame(input int line, input logic [7:0] data, input int pmode,
                              input logic pbit, input logic stop_lvl);
        drive(line, 1'b0);
        #(BIT_NS);
        for (int i = 0; i < 8; i++) begin
            drive(line, data[i]);
            #(BIT_NS);
        end
        if (pmode != PAR_NONE) begin
            drive(line, pbit);
            #(BIT_NS);
        end
        drive(line, stop_lvl);
        if (stop_lvl) #(BIT_NS);
        else          #(12 * TICK_NS);
        drive(line, 1'b1);
    endtask

    task automatic expect_one(input int line, input string tag, input logic [9:0] exp);
        logic [9:0] got;
        check({tag, "_count"}, mon_q[line].size(), 1);
        if (mon_q[line].size() > 0) begin
            got = mon_q[line].pop_front();
            check(tag, {22'd0, got}, {22'd0, exp});
        end
        mon_q[line].delete();
        mon_t[line].delete();
    endtask

    initial begin
        #100;
        reset = 1'b0;
        #100;
        check("rst_dout0", {24'd0, dout0}, 32'h0);
        check("rst_done0", {31'd0, done0}, 32'h0);
        check("rst_ferr0", {31'd0, ferr0}, 32'h0);
        check("rst_perr0", {31'd0, perr0}, 32'h0);
        check("rst_perr1", {31'd0, perr1}, 32'h0);
        check("rst_dout2", {24'd0, dout2}, 32'h0);

        send_frame(0, 8'hA5, PAR_NONE, 1'b0, 1'b1);
        #2000;
        expect_one(0, "frame_a5", model(8'hA5, PAR_NONE, 1'b0, 1'b1));

        drive(0, 1'b0);
        #3000;
        drive(0, 1'b1);
        #12000;
        check("glitch_count", mon_q[0].size(), 0);
        check("glitch_dout", {24'd0, dout0}, 32'hA5);

        send_frame(0, 8'h3C, PAR_NONE, 1'b0, 1'b0);
        #4000;
        expect_one(0, "ferr_3c", model(8'h3C, PAR_NONE, 1'b0, 1'b0));
        send_frame(0, 8'h55, PAR_NONE, 1'b0, 1'b1);
        #2000;
        expect_one(0, "good_55", model(8'h55, PAR_NONE, 1'b0, 1'b1));

        fork
            send_frame(1, 8'h07, PAR_EVEN, 1'b1, 1'b1);
            send_frame(2, 8'h07, PAR_ODD,  1'b0, 1'b1);
        join
        #2000;
        expect_one(1, "even_ok", model(8'h07, PAR_EVEN, 1'b1, 1'b1));
        expect_one(2, "odd_ok",  model(8'h07, PAR_ODD,  1'b0, 1'b1));
        send_frame(1, 8'h07, PAR_EVEN, 1'b0, 1'b1);
        #2000;
        expect_one(1, "even_bad", model(8'h07, PAR_EVEN, 1'b0, 1'b1));

        fork
            send_frame(0, 8'hFF, PAR_NONE, 1'b0, 1'b1);
            begin
                #(BIT_NS * 5 + BIT_NS / 2);
                reset = 1'b1;
                #50;
                reset = 1'b0;
            end
        join
        #2000;
        check("midrst_count", mon_q[0].size(), 0);
        check("midrst_dout0", {24'd0, dout0}, 32'h0);
        check("midrst_dout1", {24'd0, dout1}, 32'h0);
        mon_q[0].delete();
        mon_t[0].delete();
        send_frame(0, 8'h81, PAR_NONE, 1'b0, 1'b1);
        #2000;
        expect_one(0, "after_rst_81", model(8'h81, PAR_NONE, 1'b0, 1'b1));

        send_frame(0, 8'h12, PAR_NONE, 1'b0, 1'b1);
        send_frame(0, 8'h34, PAR_NONE, 1'b0, 1'b1);
        #2000;
        check("b2b_count", mon_q[0].size(), 2);
        if (mon_q[0].size() == 2) begin
            longint diff;
            longint dev;
            diff = mon_t[0][1] - mon_t[0][0];
            dev  = (diff > 86400) ? diff - 86400 : 86400 - diff;
            check("b2b_first",  {22'd0, mon_q[0][0]}, {22'd0, model(8'h12, PAR_NONE, 1'b0, 1'b1)});
            check("b2b_second", {22'd0, mon_q[0][1]}, {22'd0, model(8'h34, PAR_NONE, 1'b0, 1'b1)});
            check("b2b_spacing", (dev <= TICK_NS) ? 32'd86400 : 32'(diff), 32'd86400);
        end
        mon_q[0].delete();
        mon_t[0].delete();

        for (int r = 0; r < 3; r++) begin
            logic [7:0] d0, d1, d2;
            logic       p1, p2, s0, s1, s2;
            d0 = 8'($urandom); d1 = 8'($urandom); d2 = 8'($urandom);
            p1 = 1'($urandom); p2 = 1'($urandom);
            s0 = ($urandom_range(0, 3) != 0);
            s1 = ($urandom_range(0, 3) != 0);
            s2 = ($urandom_range(0, 3) != 0);
            fork
                send_frame(0, d0, PAR_NONE, 1'b0, s0);
                send_frame(1, d1, PAR_EVEN, p1, s1);
                send_frame(2, d2, PAR_ODD,  p2, s2);
            join
            #4000;
            expect_one(0, $sformatf("rand%0d_none", r), model(d0, PAR_NONE, 1'b0, s0));
            expect_one(1, $sformatf("rand%0d_even", r), model(d1, PAR_EVEN, p1, s1));
            expect_one(2, $sformatf("rand%0d_odd",  r), model(d2, PAR_ODD,  p2, s2));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
# uart_rx

Oversampling UART receiver that sits directly downstream of the baud-rate generator `b_gen` and consumes its `max_tick` output as a 16x-oversampling strobe. Recovers asynchronous serial frames from the `rx` line: one start bit, DBIT data bits LSB first, optional parity, and a stop interval. Delivers each received word with a one-cycle done strobe and error flags. Intended to feed a receive FIFO or register interface.

## Interface
- `DBIT`, default 8: number of data bits per frame (5–9).
- `SB_TICK`, default 16: oversampling ticks in the stop interval (16/24/32 = 1/1.5/2 stop bits).
- `PARITY`, default 0: 0 = none, 1 = even, 2 = odd.

- `clk`  in  1: system clock (50 MHz nominal).
- `reset`  in  1: asynchronous, active-high reset.
- `rx`  in  1: serial line, asynchronous to `clk`, idle high.
- `s_tick`  in  1: one-cycle strobe at 16x the baud rate, connected to `b_gen.max_tick`.
- `dout`  out  DBIT: last received data word.
- `rx_done_tick`  out  1: one-cycle pulse when a frame completes.
- `frame_err`  out  1: stop bit sampled low; valid with `rx_done_tick`.
- `parity_err`  out  1: parity mismatch; valid with `rx_done_tick`; always 0 when PARITY=0.

## Operation
- `rx` passes through a 2-flop synchronizer. The synchronizer flops reset to 1. Every reference to "rx" below means the synchronized value `rx_s`.
- FSM states: IDLE, START, DATA, PAR, STOP. Registers:
  - `s` (4-bit) counts ticks.
  - `n` (ceil(log2 DBIT)-bit) counts bits.
  - `b` (DBIT) is the shift register.
  - `p` (1) is the running parity.
- IDLE: when `rx_s`=0, go to START and clear `s`. The transition happens on that clock edge and does not wait for `s_tick`.
- START: on each `s_tick`, increment `s`. When `s`=7 is reached with a tick:
  - If `rx_s`=0: go to DATA, clear `s`, `n` and `p`.
  - If `rx_s`=1 (glitch): return to IDLE with no pulse.
- DATA: on each `s_tick`, increment `s`. At `s`=15 with a tick:
  - Update `b` ← {`rx_s`, `b`[DBIT-1:1]} and `p` ← `p` ^ `rx_s`; clear `s`.
  - If `n`=DBIT-1, go to PAR when PARITY≠0, otherwise go to STOP. If not, increment `n`.
- PAR: at `s`=15 with a tick, sample the parity bit, set the parity-error latch to `p` ^ `rx_s` ^ (PARITY==2), clear `s`, and go to STOP.
- STOP: count `s_tick` ticks up to SB_TICK-1 using a counter wide enough for SB_TICK, reusing `s` extended to 5 bits. On the final tick:
  - Load `dout` ← `b`.
  - Set `frame_err` ← ~`rx_s` and `parity_err` ← the latched error.
  - Pulse `rx_done_tick`.
  - Return to IDLE.
- Without `s_tick`, every counter and state holds. No state advances except IDLE→START.
- A framing error still delivers `dout`. A line held low (break) causes IDLE→START again immediately after STOP; the next frame is accepted normally.

## Timing
- Reset values: `dout`=0, `rx_done_tick`=0, `frame_err`=0, `parity_err`=0, state=IDLE, all counters 0, synchronizer=1.
- Input latency: 2 clocks from `rx` to `rx_s`.
- Sample points fall at the middle of each bit: 8 ticks after the falling edge, then every 16 ticks.
- `rx_done_tick` is high for exactly one `clk` cycle, in the cycle after the final STOP tick is registered. `dout` and the error flags change in the same cycle and hold until the next done pulse.
- Minimum frame spacing: none. A start edge in the cycle after `rx_done_tick` is accepted.
- Reset asserted mid-frame: immediate return to IDLE, no done pulse, `dout` cleared.
- M=27 at 50 MHz gives 115 741 baud (0.47 % error vs 115 200). One bit lasts 432 clocks (8 640 ns).

## Structure
- Package `uart_pkg`:
  - `rx_state_t` enum (IDLE, START, DATA, PAR, STOP).
  - Parity encoding constants `PAR_NONE`/`PAR_EVEN`/`PAR_ODD`.
  - Oversample constant `OVS=16`.
  - Shared later with `uart_tx`.
- Sub-module `sync_2ff`: a generic 2-flop synchronizer with reset value parameter `RST_VAL`, instantiated once for `rx`.
- FSM uses the two-process style with `_reg`/`_next` pairs.
- Bench instantiates `b_gen #(.M(27),.N(5))` driving `s_tick`, with a 20 ns clock.

## Test plan
- 8N1 frame 0xA5 (bits 1,0,1,0,0,1,0,1 LSB first, 8 640 ns per bit) → a single `rx_done_tick`, `dout`=0xA5, `frame_err`=0, `parity_err`=0.
- `rx` low pulse of 3 000 ns (less than 8 ticks) while idle → FSM returns to IDLE, no `rx_done_tick`, `dout` unchanged.
- Frame 0x3C with the stop bit held low → `dout`=0x3C, `frame_err`=1 with the pulse. A following good frame 0x55 gives `frame_err`=0.
- PARITY=1: frame 0x07 with parity bit 1 → `parity_err`=0. Same data with parity bit 0 → `parity_err`=1. PARITY=2 with parity bit 0 → `parity_err`=0.
- Assert `reset` for 50 ns during DATA bit 4 of 0xFF → no `rx_done_tick`, `dout`=0. A subsequent frame 0x81 is received correctly.
- Two back-to-back frames 0x12, 0x34 with no idle gap → two pulses, 10 bit-times apart (86 400 ns ± 1 tick), with `dout` 0x12 then 0x34.
